// File: rtl/rcs_pkg.sv
// Shared constants, split-point helper and stage-1 bundle type for the
// two-stage ripple-borrow subtractor.
package rcs_pkg;

    localparam int unsigned RCS_DEFAULT_WIDTH = 8;

    // Number of low-order bits resolved in stage 1.
    function automatic int unsigned rcs_lo(input int unsigned width);
        return width / 2;
    endfunction

    localparam int unsigned RCS_DEFAULT_LO = rcs_lo(RCS_DEFAULT_WIDTH);
    localparam int unsigned RCS_DEFAULT_HI = RCS_DEFAULT_WIDTH - RCS_DEFAULT_LO;

    // Stage-1 register bundle at the default width.
    typedef struct packed {
        logic [RCS_DEFAULT_LO-1:0] d_lo;
        logic [RCS_DEFAULT_HI-1:0] a_hi;
        logic [RCS_DEFAULT_HI-1:0] b_hi;
        logic                      b1;
        logic                      valid;
    } rcs_s1_t;

endpackage

// File: rtl/rcs_ripple_seg.sv
// Combinational N-bit ripple-borrow subtract segment: {bo, d} = x - y - bi.
module rcs_ripple_seg #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bi,
    output logic [N-1:0] d,
    output logic         bo
);

    logic [N:0] brw;

    always_comb begin
        brw    = '0;
        d      = '0;
        brw[0] = bi;
        for (int i = 0; i < int'(N); i++) begin
            d[i]     = x[i] ^ y[i] ^ brw[i];
            // Borrow when x < y + borrow at this bit.
            brw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
        end
        bo = brw[N];
    end

endmodule

// File: rtl/rcs_2stage_pipe.sv
// Two-stage pipelined ripple-borrow subtractor with valid/ready on both sides.
// Optional signed-overflow output ovf when RCS_OVERFLOW_FLAG_EN is defined.
module rcs_2stage_pipe
    import rcs_pkg::*;
#(
    parameter int unsigned WIDTH = RCS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef RCS_OVERFLOW_FLAG_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int unsigned LO = rcs_lo(WIDTH);
    localparam int unsigned HI = WIDTH - LO;

    typedef struct packed {
        logic [LO-1:0] d_lo;
        logic [HI-1:0] a_hi;
        logic [HI-1:0] b_hi;
        logic          b1;
        logic          valid;
    } s1_t;

    s1_t             s1_d, s1_q;
    logic            out_valid_d, out_valid_q;
    logic [WIDTH-1:0] diff_d, diff_q;
    logic            bout_d, bout_q;

    logic [LO-1:0]   d_lo_c;
    logic            b1_c;
    logic [HI-1:0]   d_hi_c;
    logic            bout_c;
    logic            s2_ready_c;

    rcs_ripple_seg #(.N(LO)) u_seg_lo (
        .x  (a[LO-1:0]),
        .y  (b[LO-1:0]),
        .bi (bin),
        .d  (d_lo_c),
        .bo (b1_c)
    );

    rcs_ripple_seg #(.N(HI)) u_seg_hi (
        .x  (s1_q.a_hi),
        .y  (s1_q.b_hi),
        .bi (s1_q.b1),
        .d  (d_hi_c),
        .bo (bout_c)
    );

    // Handshake: a stage accepts when it is empty or its successor drains.
    always_comb begin
        s2_ready_c = !out_valid_q || out_ready;
        in_ready   = !s1_q.valid || s2_ready_c;
    end

    always_comb begin
        s1_d = s1_q;
        if (in_ready) begin
            s1_d.d_lo  = d_lo_c;
            s1_d.a_hi  = a[WIDTH-1:LO];
            s1_d.b_hi  = b[WIDTH-1:LO];
            s1_d.b1    = b1_c;
            s1_d.valid = in_valid;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        if (s2_ready_c) begin
            out_valid_d = s1_q.valid;
            diff_d      = {d_hi_c, s1_q.d_lo};
            bout_d      = bout_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef RCS_OVERFLOW_FLAG_EN
    logic a_msb_d, a_msb_q;
    logic b_msb_d, b_msb_q;
    logic ovf_d, ovf_q;

    // Signed overflow: operand signs differ and the result sign leaves a's.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (in_ready) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        if (s2_ready_c) begin
            ovf_d = (a_msb_q != b_msb_q) && (d_hi_c[HI-1] != a_msb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rcs_2stage_pipe.sv
// Randomized and directed bench for rcs_2stage_pipe against a queue-based
// arithmetic reference model.
module tb_rcs_2stage_pipe;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef RCS_OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    rcs_2stage_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef RCS_OVERFLOW_FLAG_EN
        .bout      (bout),
        .ovf       (ovf)
`else
        .bout      (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           te;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    bit   exp_v;
    bit   exp_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Golden result from plain integer arithmetic.
    function automatic exp_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic bi, input int te);
        exp_t e;
        int   ur;
        int   sr;
        ur     = int'(x) - int'(y) - int'(bi);
        sr     = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.diff = W'(ur + (1 << W));
        e.bout = (ur < 0);
        e.ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
        e.te   = te;
        return e;
    endfunction

    // Cycle monitor: the queue holds every accepted item not yet delivered.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_v   = (q.size() > 0) && (cyc >= q[0].te + 1);
            exp_rdy = (q.size() < 2) || out_ready;
            check_eq("out_valid", 32'(out_valid), 32'(exp_v));
            check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (out_valid && q.size() > 0) begin
                check_eq("diff", 32'(diff), 32'(q[0].diff));
                check_eq("bout", 32'(bout), 32'(q[0].bout));
`ifdef RCS_OVERFLOW_FLAG_EN
                check_eq("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(a, b, bin, cyc + 1));
                n_in++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    // Single transfer into an otherwise idle pipe; checks latency and value.
    task automatic send_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi,
                            input logic [W-1:0] exp_d, input logic exp_b);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        bin      = xbi;
        tick();
        in_valid = 1'b0;
        check_eq("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat2_valid", 32'(out_valid), 32'd1);
        check_eq("dir_diff", 32'(diff), 32'(exp_d));
        check_eq("dir_bout", 32'(bout), 32'(exp_b));
    endtask

    int           base_in;
    int           base_out;
    logic [W-1:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        send_one(8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
`ifdef RCS_OVERFLOW_FLAG_EN
        check_eq("ovf_none", 32'(ovf), 32'd0);
`endif
        send_one(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        send_one(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
`ifdef RCS_OVERFLOW_FLAG_EN
        send_one(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        check_eq("ovf_neg", 32'(ovf), 32'd1);
        send_one(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
        check_eq("ovf_pos", 32'(ovf), 32'd1);
`endif
        repeat (2) tick();

        // Back-to-back stream at full throughput.
        base_out = n_out;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("stream_count", 32'(n_out - base_out), 32'd16);
        check_eq("stream_drain", 32'(q.size()), 32'd0);

        // Backpressure: downstream stalls while the source keeps offering.
        base_in   = n_in;
        base_out  = n_out;
        out_ready = 1'b0;
        held      = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
            if (i == 1) held = diff;
        end
        check_eq("bp_accepted", 32'(n_in - base_in), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_stable", 32'(diff), 32'(held));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check_eq("bp_count", 32'(n_out - base_out), 32'd6);
        check_eq("bp_drain", 32'(q.size()), 32'd0);

        // Reset with two items in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_diff", 32'(diff), 32'd0);
        check_eq("mid_rst_bout", 32'(bout), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        base_out  = n_out;
        repeat (4) tick();
        check_eq("mid_rst_no_stale", 32'(n_out - base_out), 32'd0);

        // Random mix of source and sink activity.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_ops();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check_eq("rand_drain", 32'(q.size()), 32'd0);
        check_eq("in_out_balance", 32'(n_out), 32'(n_in - 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
